mips_run_ctrl: RTL
==================

// Module: mips_run_ctrl
// PURPOSE
//  Run controller for the single-clock MIPS core. Streams a program from a host
//  into the core's instruction write port (instruction word + write enable) while
//  the core is held in reset. It then releases the core, runs it, and stops it on a
//  self-loop halt or a cycle limit. Sits between the host/board logic and the core top.
// PARAMETERS
//  LEN_W      9   width of prog_len; max program = 2**LEN_W-1 words
//  CYC_W      32  width of cycle counter
//  MAX_CYCLES 0   run-cycle limit; 0 = unlimited
// PORTS
//  CLK        in   1      clock, rising edge
//  RST        in   1      asynchronous, active-low reset
//  start      in   1      pulse: begin load (honoured in IDLE/DONE only)
//  abort      in   1      return to IDLE from any state
//  prog_len   in   LEN_W  words to load; sampled on accepted start
//  ld_valid   in   1      host word valid
//  ld_data    in   32     host instruction word
//  ld_ready   out  1      controller accepts word this cycle
//  core_pc    in   32     current PC from core
//  core_rst_n out  1      reset to core, active-low
//  core_ce    out  1      core advance enable
//  w_ins      out  32     instruction word to core write port
//  we         out  1      instruction write enable to core
//  busy       out  1      state is LOAD, FLUSH or RUN
//  done       out  1      state is DONE
//  timeout    out  1      DONE was reached by the MAX_CYCLES limit
//  halted_pc  out  32     PC captured on halt
//  cyc_cnt    out  CYC_W  enabled run cycles since release
// BEHAVIOUR
//  Reset: state=IDLE. core_rst_n=0; all other outputs 0.
//  States: IDLE, LOAD, FLUSH, RUN, DONE. abort has top priority: next state IDLE, done/timeout cleared.
//  IDLE
//   - core_rst_n=0, core_ce=0, ld_ready=0.
//   - start with prog_len!=0 -> LOAD: word count=0, cyc_cnt=0, halted_pc=0.
//   - start with prog_len==0 is ignored.
//  LOAD
//   - core_rst_n=0, ld_ready=1. Accept = ld_valid & ld_ready.
//   - Each accept registers w_ins<=ld_data and we<=1; otherwise we<=0. Write latency is 1 cycle.
//   - The core stores one word per we cycle, in order.
//   - The accept of word prog_len-1 -> FLUSH.
//  FLUSH
//   - One cycle, ld_ready=0, core_rst_n=0 so the last write lands. Then -> RUN.
//  RUN
//   - core_rst_n=1, core_ce=1, cyc_cnt+1 per enabled cycle; cyc_cnt saturates at all-ones.
//   - Halt: on an enabled cycle, core_pc equals core_pc from the previous enabled cycle on 2 consecutive enabled cycles (j/beq to self).
//     The first enabled cycle after release has no previous PC and never matches.
//     On halt -> DONE, halted_pc<=core_pc, timeout=0.
//   - Limit: MAX_CYCLES!=0 and cyc_cnt reaches MAX_CYCLES -> DONE, halted_pc<=core_pc, timeout=1.
//     If both conditions occur in the same cycle, halt wins (timeout=0).
//  DONE
//   - core_ce=0, core_rst_n=1 (core state held for inspection).
//   - start with prog_len!=0 -> LOAD (core_rst_n back to 0).
//  Other rules:
//   - start while busy is ignored.
//   - A word presented in the same cycle as abort is discarded (we=0 next cycle).
//   - Asserting RST mid-operation returns to reset state immediately.
// CONFIGURATION
//  SINGLE_STEP_EN defined: adds inputs step_mode (1) and step (1).
//   - In RUN with step_mode=1, core_ce=1 for exactly one cycle following each rising edge of step.
//   - cyc_cnt and halt/limit checks advance only on core_ce cycles.
//   - step_mode=0 gives continuous run.
//  SINGLE_STEP_EN undefined: the step ports do not exist and RUN is continuous.
// TESTING
//  1. prog_len=3, ld_valid held 1 -> ld_ready 3 cycles, we high 3 cycles with w_ins=words in order one cycle late, core_rst_n rises 2 cycles after last accept.
//  2. prog_len=4, ld_valid toggling 1,0,1,0... -> exactly 4 we pulses, order preserved, no write on idle cycles.
//  3. Program ending "j 0x0C" -> done=1 after detection, halted_pc=0x0000000C, timeout=0, core_ce=0.
//  4. MAX_CYCLES=16, loop alternating PC 0x0/0x4 -> done at cyc_cnt=16, timeout=1.
//  5. abort with ld_valid=1 mid-LOAD -> IDLE next cycle, we=0, done=0; new start reloads from word 0.
//  6. SINGLE_STEP_EN, step_mode=1, 3 step pulses -> exactly 3 core_ce cycles, cyc_cnt=3.

Source files
------------

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-clock MIPS core: loads a program into the core while
// it is held in reset, then runs it until a self-loop halt or the cycle limit.
// Optional build macro SINGLE_STEP_EN adds step_mode/step for single-cycle stepping.
module mips_run_ctrl #(
  parameter int unsigned LEN_W      = 9,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] prog_len,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  input  logic [31:0]      core_pc,
  output logic             core_rst_n,
  output logic             core_ce,
  output logic [31:0]      w_ins,
  output logic             we,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [31:0]      halted_pc,
  output logic [CYC_W-1:0] cyc_cnt
`ifdef SINGLE_STEP_EN
  ,
  input  logic             step_mode,
  input  logic             step
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, wcnt;
  logic [31:0]      prev_pc;
  logic             have_prev, prev_match;
  logic             start_ok, accept, take, last_word;
  logic             run_en, pc_match, halt, limit;
  logic [CYC_W-1:0] cyc_inc;

`ifdef SINGLE_STEP_EN
  logic step_d, step_pulse;

  // A rising edge of step grants exactly one enabled cycle, one clock later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      step_d     <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      step_d     <= step;
      step_pulse <= step & ~step_d;
    end
  end

  assign run_en = (state == S_RUN) && (!step_mode || step_pulse);
`else
  assign run_en = (state == S_RUN);
`endif

  assign start_ok  = start && (prog_len != '0);
  assign accept    = ld_valid && ld_ready;
  assign take      = accept && !abort;
  assign last_word = accept && (wcnt == len_q - LEN_W'(1));
  assign pc_match  = have_prev && (core_pc == prev_pc);
  assign halt      = run_en && pc_match && prev_match;
  assign cyc_inc   = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + CYC_W'(1);
  assign limit     = run_en && (MAX_CYCLES != 0) && (cyc_inc == CYC_W'(MAX_CYCLES));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: if (start_ok) state_nxt = S_LOAD;
        S_LOAD:         if (last_word) state_nxt = S_FLUSH;
        S_FLUSH:        state_nxt = S_RUN;
        S_RUN:          if (halt || limit) state_nxt = S_DONE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_ready   = (state == S_LOAD);
    core_rst_n = (state == S_RUN) || (state == S_DONE);
    core_ce    = run_en;
    busy       = (state == S_LOAD) || (state == S_FLUSH) || (state == S_RUN);
    done       = (state == S_DONE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      w_ins      <= '0;
      we         <= 1'b0;
      timeout    <= 1'b0;
      halted_pc  <= '0;
      cyc_cnt    <= '0;
      len_q      <= '0;
      wcnt       <= '0;
      prev_pc    <= '0;
      have_prev  <= 1'b0;
      prev_match <= 1'b0;
    end else begin
      we <= take;
      if (take) begin
        w_ins <= ld_data;
        wcnt  <= wcnt + LEN_W'(1);
      end
      if (!abort && start_ok && (state == S_IDLE || state == S_DONE)) begin
        len_q     <= prog_len;
        wcnt      <= '0;
        cyc_cnt   <= '0;
        halted_pc <= '0;
        timeout   <= 1'b0;
      end
      // Halt compares against the PC of the previous enabled cycle only.
      if (state != S_RUN) begin
        have_prev  <= 1'b0;
        prev_match <= 1'b0;
      end else if (run_en && !abort) begin
        cyc_cnt    <= cyc_inc;
        prev_pc    <= core_pc;
        have_prev  <= 1'b1;
        prev_match <= pc_match;
        if (halt) begin
          halted_pc <= core_pc;
          timeout   <= 1'b0;
        end else if (limit) begin
          halted_pc <= core_pc;
          timeout   <= 1'b1;
        end
      end
      if (abort) timeout <= 1'b0;
    end
  end

endmodule
